// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: hazard-controller state encoding and register constants.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_perf_counters.sv
// Stall, flush and cycle performance counters; each wraps at 2^CNT_W.
module hazard_perf_counters #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_inc,
  input  logic             flush_inc,
  input  logic             cycle_inc,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] cycle_cnt
);

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;

  // Next-count computation from the increment strobes
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    if (stall_inc) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_inc) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    if (cycle_inc) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
  end

  // Counter registers, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      cycle_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign cycle_cnt = cycle_cnt_q;

endmodule

// File: rtl/hazard_sequencer.sv
// Central stall/flush controller for the 5-stage pipeline registers and PC.
module hazard_sequencer
  import cpu_types_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             exmem_dread,
  input  logic             exmem_dwrite,
  input  logic             exmem_br_taken,
  input  logic             exmem_jr,
  input  logic             ifid_jump,
  input  logic             idex_dread,
  input  logic [4:0]       idex_rt,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             memwb_halt,
  output logic             pc_en,
  output logic             IF_EN,
  output logic             ID_EN,
  output logic             EX_EN,
  output logic             MEM_EN,
  output logic             IF_FLUSH,
  output logic             ID_FLUSH,
  output logic             EX_FLUSH,
  output logic             MEM_FLUSH,
  output logic             imem_ren,
  output logic             dmem_gate,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] cycle_cnt
);

  hz_state_t state_q, state_d;
  logic      halt_q, halt_d;
  logic      dpend, load_use, flush_inc;

  assign dpend    = exmem_dread | exmem_dwrite;
  assign load_use = idex_dread & (idex_rt != REG_ZERO) &
                    ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));

  // Priority resolution of halt, data wait, control transfer, load-use and fetch miss
  always_comb begin
    state_d   = state_q;
    halt_d    = halt_q;
    flush_inc = 1'b0;
    pc_en     = 1'b0;
    IF_EN     = 1'b0;
    ID_EN     = 1'b0;
    EX_EN     = 1'b0;
    MEM_EN    = 1'b0;
    IF_FLUSH  = 1'b0;
    ID_FLUSH  = 1'b0;
    EX_FLUSH  = 1'b0;
    MEM_FLUSH = 1'b0;
    imem_ren  = 1'b0;
    dmem_gate = 1'b0;
    if (RST) begin
      IF_FLUSH  = 1'b1;
      ID_FLUSH  = 1'b1;
      EX_FLUSH  = 1'b1;
      MEM_FLUSH = 1'b1;
      state_d   = RUN;
      halt_d    = 1'b0;
    end else if (state_q == HALTED) begin
      halt_d = 1'b1;
    end else if (memwb_halt) begin
      state_d = HALTED;
      halt_d  = 1'b1;
    end else if (dpend && !dhit) begin
      dmem_gate = 1'b1;
      state_d   = DWAIT;
    end else begin
      // Free-running defaults; the cases below only carve out exceptions
      state_d   = RUN;
      pc_en     = 1'b1;
      IF_EN     = 1'b1;
      ID_EN     = 1'b1;
      EX_EN     = 1'b1;
      MEM_EN    = 1'b1;
      imem_ren  = 1'b1;
      dmem_gate = 1'b1;
      if (exmem_br_taken || exmem_jr) begin
        IF_FLUSH  = 1'b1;
        ID_FLUSH  = 1'b1;
        EX_FLUSH  = 1'b1;
        flush_inc = 1'b1;
      end else if (load_use) begin
        pc_en    = 1'b0;
        IF_EN    = 1'b0;
        ID_FLUSH = 1'b1;
      end else if (!ihit) begin
        pc_en    = 1'b0;
        IF_FLUSH = 1'b1;
      end else if (ifid_jump) begin
        IF_FLUSH  = 1'b1;
        flush_inc = 1'b1;
      end
    end
  end

  // FSM state and sticky halt registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
    end
  end

  assign halt = halt_q;

  hazard_perf_counters #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk       (CLK),
    .rst       (RST),
    .stall_inc (!RST && (state_q != HALTED) && !pc_en),
    .flush_inc (flush_inc),
    .cycle_inc (!RST && (state_q != HALTED)),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt),
    .cycle_cnt (cycle_cnt)
  );

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed-vector bench for hazard_sequencer.
module tb_hazard_sequencer;

  localparam int unsigned CNT_W = 32;

  logic             CLK = 1'b0;
  logic             RST;
  logic             ihit, dhit;
  logic             exmem_dread, exmem_dwrite, exmem_br_taken, exmem_jr;
  logic             ifid_jump, idex_dread, memwb_halt;
  logic [4:0]       idex_rt, ifid_rs, ifid_rt;
  logic             pc_en, IF_EN, ID_EN, EX_EN, MEM_EN;
  logic             IF_FLUSH, ID_FLUSH, EX_FLUSH, MEM_FLUSH;
  logic             imem_ren, dmem_gate, halt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, cycle_cnt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 CLK = ~CLK;

  hazard_sequencer #(
    .CNT_W (CNT_W)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .ihit           (ihit),
    .dhit           (dhit),
    .exmem_dread    (exmem_dread),
    .exmem_dwrite   (exmem_dwrite),
    .exmem_br_taken (exmem_br_taken),
    .exmem_jr       (exmem_jr),
    .ifid_jump      (ifid_jump),
    .idex_dread     (idex_dread),
    .idex_rt        (idex_rt),
    .ifid_rs        (ifid_rs),
    .ifid_rt        (ifid_rt),
    .memwb_halt     (memwb_halt),
    .pc_en          (pc_en),
    .IF_EN          (IF_EN),
    .ID_EN          (ID_EN),
    .EX_EN          (EX_EN),
    .MEM_EN         (MEM_EN),
    .IF_FLUSH       (IF_FLUSH),
    .ID_FLUSH       (ID_FLUSH),
    .EX_FLUSH       (EX_FLUSH),
    .MEM_FLUSH      (MEM_FLUSH),
    .imem_ren       (imem_ren),
    .dmem_gate      (dmem_gate),
    .halt           (halt),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt),
    .cycle_cnt      (cycle_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Quiet pipeline: fetch hitting, nothing pending
  task automatic idle_inputs();
    ihit = 1'b1; dhit = 1'b0;
    exmem_dread = 1'b0; exmem_dwrite = 1'b0; exmem_br_taken = 1'b0; exmem_jr = 1'b0;
    ifid_jump = 1'b0; idex_dread = 1'b0; memwb_halt = 1'b0;
    idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
  endtask

  // Inputs are changed 1 time unit after a rising edge; settle before checking
  task automatic settle();
    #2;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 1'b1;
    settle();
    check_eq("rst_pc_en", {31'd0, pc_en}, 32'd0);
    check_eq("rst_en", {28'd0, IF_EN, ID_EN, EX_EN, MEM_EN}, 32'h0);
    check_eq("rst_flush", {28'd0, IF_FLUSH, ID_FLUSH, EX_FLUSH, MEM_FLUSH}, 32'hF);
    check_eq("rst_gates", {30'd0, imem_ren, dmem_gate}, 32'd0);
    step();
    RST = 1'b0;
    check_eq("rst_halt", {31'd0, halt}, 32'd0);
    check_eq("rst_stall_cnt", stall_cnt, 32'd0);
    check_eq("rst_flush_cnt", flush_cnt, 32'd0);
    check_eq("rst_cycle_cnt", cycle_cnt, 32'd0);
  endtask

  initial begin
    RST = 1'b1;
    idle_inputs();
    step();
    do_reset();

    // Idle cycle: everything advances
    settle();
    check_eq("idle_en", {27'd0, pc_en, IF_EN, ID_EN, EX_EN, MEM_EN}, 32'h1F);
    check_eq("idle_flush", {28'd0, IF_FLUSH, ID_FLUSH, EX_FLUSH, MEM_FLUSH}, 32'h0);
    check_eq("idle_gates", {30'd0, imem_ren, dmem_gate}, 32'h3);
    step();
    check_eq("idle_cycle_cnt", cycle_cnt, 32'd1);

    // 1. Load-use: one bubble, then ID/EX is no longer a load
    do_reset();
    idex_dread = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5; ifid_rt = 5'd7;
    settle();
    check_eq("lu_pc_en", {31'd0, pc_en}, 32'd0);
    check_eq("lu_if_en", {31'd0, IF_EN}, 32'd0);
    check_eq("lu_id_flush", {31'd0, ID_FLUSH}, 32'd1);
    check_eq("lu_ex_mem_en", {30'd0, EX_EN, MEM_EN}, 32'h3);
    step();
    idex_dread = 1'b0;
    settle();
    check_eq("lu_after_pc_en", {31'd0, pc_en}, 32'd1);
    check_eq("lu_after_id_flush", {31'd0, ID_FLUSH}, 32'd0);
    step();
    check_eq("lu_stall_cnt", stall_cnt, 32'd1);
    check_eq("lu_cycle_cnt", cycle_cnt, 32'd2);
    // Variant matching on rt with r0 destination: no stall
    idex_dread = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
    settle();
    check_eq("lu_r0_pc_en", {31'd0, pc_en}, 32'd1);
    check_eq("lu_r0_id_flush", {31'd0, ID_FLUSH}, 32'd0);
    // Match through rt operand
    idex_rt = 5'd9; ifid_rt = 5'd9; ifid_rs = 5'd3;
    settle();
    check_eq("lu_rt_pc_en", {31'd0, pc_en}, 32'd0);
    step();
    check_eq("lu_rt_stall_cnt", stall_cnt, 32'd2);

    // 2. Data wait for 3 cycles then dhit
    do_reset();
    exmem_dread = 1'b1; dhit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check_eq("dw_en", {27'd0, pc_en, IF_EN, ID_EN, EX_EN, MEM_EN}, 32'h0);
      check_eq("dw_gates", {30'd0, imem_ren, dmem_gate}, 32'h1);
      step();
    end
    dhit = 1'b1;
    settle();
    check_eq("dw_hit_en", {27'd0, pc_en, IF_EN, ID_EN, EX_EN, MEM_EN}, 32'h1F);
    step();
    exmem_dread = 1'b0; dhit = 1'b0;
    check_eq("dw_stall_cnt", stall_cnt, 32'd3);
    check_eq("dw_cycle_cnt", cycle_cnt, 32'd4);

    // 3. Branch taken beats load-use and fetch miss
    do_reset();
    exmem_br_taken = 1'b1; ihit = 1'b0;
    idex_dread = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
    settle();
    check_eq("br_flush", {28'd0, IF_FLUSH, ID_FLUSH, EX_FLUSH, MEM_FLUSH}, 32'hE);
    check_eq("br_pc_mem_en", {30'd0, pc_en, MEM_EN}, 32'h3);
    step();
    check_eq("br_flush_cnt", flush_cnt, 32'd1);
    check_eq("br_stall_cnt", stall_cnt, 32'd0);
    // JR behaves as a control transfer as well
    idle_inputs();
    exmem_jr = 1'b1;
    settle();
    check_eq("jr_flush", {28'd0, IF_FLUSH, ID_FLUSH, EX_FLUSH, MEM_FLUSH}, 32'hE);
    step();
    check_eq("jr_flush_cnt", flush_cnt, 32'd2);

    // 4. Branch deferred while a store waits
    do_reset();
    exmem_dwrite = 1'b1; dhit = 1'b0; exmem_br_taken = 1'b1;
    for (int i = 0; i < 2; i++) begin
      settle();
      check_eq("brdw_flush", {28'd0, IF_FLUSH, ID_FLUSH, EX_FLUSH, MEM_FLUSH}, 32'h0);
      check_eq("brdw_pc_en", {31'd0, pc_en}, 32'd0);
      step();
    end
    check_eq("brdw_flush_cnt_wait", flush_cnt, 32'd0);
    dhit = 1'b1;
    settle();
    check_eq("brdw_hit_flush", {28'd0, IF_FLUSH, ID_FLUSH, EX_FLUSH, MEM_FLUSH}, 32'hE);
    check_eq("brdw_hit_pc_en", {31'd0, pc_en}, 32'd1);
    step();
    check_eq("brdw_flush_cnt", flush_cnt, 32'd1);
    check_eq("brdw_stall_cnt", stall_cnt, 32'd2);

    // 5. Halt: sticky, freezes counters, cleared only by reset
    do_reset();
    memwb_halt = 1'b1;
    settle();
    check_eq("hlt_en", {27'd0, pc_en, IF_EN, ID_EN, EX_EN, MEM_EN}, 32'h0);
    check_eq("hlt_not_yet", {31'd0, halt}, 32'd0);
    step();
    memwb_halt = 1'b0;
    check_eq("hlt_set", {31'd0, halt}, 32'd1);
    check_eq("hlt_cycle_cnt", cycle_cnt, 32'd1);
    for (int i = 0; i < 3; i++) begin
      settle();
      check_eq("hlt_frozen_en", {27'd0, pc_en, IF_EN, ID_EN, EX_EN, MEM_EN}, 32'h0);
      check_eq("hlt_frozen_flush", {28'd0, IF_FLUSH, ID_FLUSH, EX_FLUSH, MEM_FLUSH}, 32'h0);
      check_eq("hlt_frozen_gates", {30'd0, imem_ren, dmem_gate}, 32'h0);
      step();
    end
    check_eq("hlt_sticky", {31'd0, halt}, 32'd1);
    check_eq("hlt_cycle_frozen", cycle_cnt, 32'd1);
    check_eq("hlt_stall_frozen", stall_cnt, 32'd1);
    do_reset();
    settle();
    check_eq("hlt_rst_run", {31'd0, pc_en}, 32'd1);

    // Reset during data wait drops the request
    exmem_dread = 1'b1; dhit = 1'b0;
    step();
    RST = 1'b1;
    settle();
    check_eq("rstdw_gate", {31'd0, dmem_gate}, 32'd0);
    step();
    RST = 1'b0;
    exmem_dread = 1'b0;
    settle();
    check_eq("rstdw_run", {31'd0, pc_en}, 32'd1);
    step();

    // 6. Jump with fetch miss, then fetch hit
    do_reset();
    ifid_jump = 1'b1; ihit = 1'b0;
    settle();
    check_eq("jmp_miss_pc_en", {31'd0, pc_en}, 32'd0);
    check_eq("jmp_miss_if_flush", {31'd0, IF_FLUSH}, 32'd1);
    step();
    check_eq("jmp_miss_flush_cnt", flush_cnt, 32'd0);
    ihit = 1'b1;
    settle();
    check_eq("jmp_hit_pc_en", {31'd0, pc_en}, 32'd1);
    check_eq("jmp_hit_if_flush", {31'd0, IF_FLUSH}, 32'd1);
    step();
    ifid_jump = 1'b0;
    check_eq("jmp_flush_cnt", flush_cnt, 32'd1);
    check_eq("jmp_stall_cnt", stall_cnt, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
